ripple_count_capture: RTL and testbench

- Synchronous capture stage downstream of the 4-bit asynchronous ripple down-counter.
- Samples the ripple counter's q bus into the system clock domain and rejects ripple transients with a two-flop synchroniser plus a stability filter.
- Tracks single-step decrements, detects 0->F wrap-around, and extends the count into a wider down-count.
- Flags illegal jumps caused by missed steps.

---
 rtl/ripple_count_capture.sv | 133 +++++++++++++
 tb/tb_ripple_count_capture.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/ripple_count_capture.sv
// ripple_count_capture: brings the q bus of a 4-bit asynchronous ripple
// down-counter into the clk domain, filters ripple transients, follows
// single-step decrements and extends the count with a wrap-tracking upper part.
module ripple_count_capture #(
  parameter int unsigned STABLE_CYC = 3,
  parameter int unsigned WIDTH      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       cnt_in,
  input  logic             en,
  input  logic             clr_err,
  output logic [WIDTH-1:0] count_out,
  output logic             step_pulse,
  output logic             underflow_pulse,
  output logic             skip_pulse,
  output logic             err
);

  typedef enum logic [1:0] {
    TRACK,
    HOLD,
    RESYNC
  } state_t;

  localparam logic [3:0]       STAB_MAX = 4'(STABLE_CYC);
  // Acceptance fires on the edge where stab_cnt becomes STABLE_CYC-1, so the
  // pre-edge count is STABLE_CYC-2; STABLE_CYC==1 accepts on the first equal edge.
  localparam logic [3:0]       ACC_AT   = (STABLE_CYC > 1) ? 4'(STABLE_CYC - 2) : 4'd0;
  localparam logic [WIDTH-5:0] EXT_ONE  = (WIDTH-4)'(1);

  logic [3:0]       s1, s2, s2_prev;
  logic [3:0]       stab_cnt;
  logic [3:0]       settled;
  logic [WIDTH-5:0] ext;
  state_t           state;
  logic             step_q, under_q, skip_q, err_q;

  logic             stable;
  logic             accept;
  logic [3:0]       v;
  logic [3:0]       d;

  assign stable = (s2 == s2_prev);
  assign accept = stable && (stab_cnt == ACC_AT);
  assign v      = s2;
  assign d      = settled - v;

  // Two-flop synchroniser plus one history stage for the stability compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '1;
      s2      <= '1;
      s2_prev <= '1;
    end else begin
      s1      <= cnt_in;
      s2      <= s1;
      s2_prev <= s2;
    end
  end

  // Stability filter: counts consecutive equal samples, saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      stab_cnt <= '0;
    end else if (!stable) begin
      stab_cnt <= '0;
    end else if (stab_cnt != STAB_MAX) begin
      stab_cnt <= stab_cnt + 4'd1;
    end
  end

  // Tracking state machine with registered count, pulses and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TRACK;
      settled <= '1;
      ext     <= '1;
      step_q  <= 1'b0;
      under_q <= 1'b0;
      skip_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      step_q  <= 1'b0;
      under_q <= 1'b0;
      skip_q  <= 1'b0;
      if (clr_err) begin
        err_q <= 1'b0;
      end
      case (state)
        TRACK: begin
          if (!en) begin
            state <= HOLD;
          end else if (accept && (d != 4'd0)) begin
            settled <= v;
            if (d == 4'd1) begin
              step_q <= 1'b1;
              if (settled == 4'd0) begin
                under_q <= 1'b1;
                ext     <= ext - EXT_ONE;
              end
            end else begin
              // Set overrides a same-edge clr_err.
              skip_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (en) begin
            state <= RESYNC;
          end
        end
        RESYNC: begin
          if (!en) begin
            state <= HOLD;
          end else if (accept) begin
            settled <= v;
            state   <= TRACK;
          end
        end
        default: state <= TRACK;
      endcase
    end
  end

  assign count_out       = {ext, settled};
  assign step_pulse      = step_q;
  assign underflow_pulse = under_q;
  assign skip_pulse      = skip_q;
  assign err             = err_q;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Scoreboard bench for ripple_count_capture (defaults: STABLE_CYC=3, WIDTH=16).
module tb_ripple_count_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cnt_in;
  logic        en;
  logic        clr_err;
  logic [15:0] count_out;
  logic        step_pulse, underflow_pulse, skip_pulse, err;

  typedef struct {
    int          cyc;
    logic [2:0]  p;     // {step, underflow, skip}
    logic [15:0] c;
    logic        e;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  ripple_count_capture #(.STABLE_CYC(3), .WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .cnt_in(cnt_in),
    .en(en),
    .clr_err(clr_err),
    .count_out(count_out),
    .step_pulse(step_pulse),
    .underflow_pulse(underflow_pulse),
    .skip_pulse(skip_pulse),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; acceptance is visible 5 posedges later (1 + 1 + STABLE_CYC).
  task automatic send(input logic [3:0] v, input logic [2:0] p, input logic [15:0] c,
                      input logic e, input int hold);
    cnt_in = v;
    if (p != 3'b000) q.push_back('{cyc + 5, p, c, e});
    repeat (hold) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: pops an expectation whenever any pulse is presented.
  always @(negedge clk) begin
    if (!rst) begin
      if (step_pulse || underflow_pulse || skip_pulse) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", 32'({step_pulse, underflow_pulse, skip_pulse}), 32'd0);
        end else begin
          mon_e = q.pop_front();
          check("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
          check("pulse_kind", 32'({step_pulse, underflow_pulse, skip_pulse}), 32'(mon_e.p));
          check("pulse_count", 32'(count_out), 32'(mon_e.c));
          check("pulse_err", 32'(err), 32'(mon_e.e));
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        mon_e = q.pop_front();
        check("pulse_timeout", 32'(cyc), 32'(mon_e.cyc));
      end
    end
  end

  initial begin
    rst = 1'b1; cnt_in = 4'hF; en = 1'b1; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("reset_pulses", 32'({step_pulse, underflow_pulse, skip_pulse}), 32'd0);
    for (int i = 0; i < 20; i++) begin
      check("reset_count", 32'(count_out), 32'hFFFF);
      check("reset_err", 32'(err), 32'd0);
      @(negedge clk);
    end

    // Full descent, wrap, one more step.
    for (int i = 14; i >= 0; i--) begin
      logic [3:0] n;
      n = i[3:0];
      send(n, 3'b100, {12'hFFF, n}, 1'b0, 8);
    end
    check("before_wrap", 32'(count_out), 32'hFFF0);
    send(4'hF, 3'b110, 16'hFFEF, 1'b0, 8);
    send(4'hE, 3'b100, 16'hFFEE, 1'b0, 8);
    check("after_wrap", 32'(count_out), 32'hFFEE);

    for (int i = 13; i >= 8; i--) begin
      logic [3:0] n;
      n = i[3:0];
      send(n, 3'b100, {12'hFFE, n}, 1'b0, 8);
    end

    // Ripple transient 8 -> 9 -> B -> 7.
    send(4'h9, 3'b000, 16'h0, 1'b0, 1);
    send(4'hB, 3'b000, 16'h0, 1'b0, 1);
    send(4'h7, 3'b100, 16'hFFE7, 1'b0, 8);
    check("transient_settled", 32'(count_out[3:0]), 32'h7);
    check("transient_err", 32'(err), 32'd0);

    send(4'h6, 3'b100, 16'hFFE6, 1'b0, 8);
    send(4'h5, 3'b100, 16'hFFE5, 1'b0, 8);

    // Hold / resync: 5 -> 2 while disabled, no pulses.
    en = 1'b0;
    repeat (2) @(negedge clk);
    send(4'h2, 3'b000, 16'h0, 1'b0, 1);
    en = 1'b1;
    repeat (10) @(negedge clk);
    check("resync_count", 32'(count_out), 32'hFFE2);
    send(4'h1, 3'b100, 16'hFFE1, 1'b0, 8);

    // Skips and err handling.
    send(4'h9, 3'b001, 16'hFFE9, 1'b1, 8);
    check("skip_err_set", 32'(err), 32'd1);
    pulse_clr();
    check("clr_err_a", 32'(err), 32'd0);
    send(4'h6, 3'b001, 16'hFFE6, 1'b1, 8);
    check("skip_ext_same", 32'(count_out), 32'hFFE6);
    pulse_clr();
    check("clr_err_b", 32'(err), 32'd0);
    clr_err = 1'b1;
    send(4'h3, 3'b001, 16'hFFE3, 1'b1, 5);
    clr_err = 1'b0;
    repeat (2) @(negedge clk);
    check("set_wins", 32'(err), 32'd1);
    repeat (3) @(negedge clk);
    send(4'hE, 3'b001, 16'hFFEE, 1'b1, 8);
    check("skip_cross_zero", 32'(count_out), 32'hFFEE);

    // Reset on the edge where D would have been accepted.
    send(4'hD, 3'b000, 16'h0, 1'b0, 4);
    rst = 1'b1;
    cnt_in = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_count", 32'(count_out), 32'hFFFF);
    check("midreset_err", 32'(err), 32'd0);
    repeat (10) @(negedge clk);
    check("midreset_quiet", 32'(count_out), 32'hFFFF);
    send(4'hE, 3'b100, 16'hFFFE, 1'b0, 8);

    repeat (10) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
